// File: rtl/pmem_pkg.sv
// Shared types and constants for the pmem burst responder.
package pmem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    DONE
  } pmem_state_t;

  localparam int unsigned LINE_BITS   = 256;
  localparam int unsigned OFFSET_BITS = 5;

  typedef logic [63:0] beat_t;
  typedef beat_t [3:0] line_t;

endpackage

// File: rtl/pmem_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) stepping on en; used for response jitter.
module pmem_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  logic feedback;

  assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[6:0], feedback};
    end
  end

endmodule

// File: rtl/pmem_burst_responder.sv
// Memory-side responder for the pmem cache-line handshake with modelled latency.
// Optional PMEM_RESP_JITTER_EN adds 0..7 LFSR-driven cycles to the access latency.
module pmem_burst_responder
  import pmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned LATENCY     = 10,
  parameter int unsigned DEPTH_LINES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_addr,
  input  logic [DATA_W-1:0] pmem_wdata,
  output logic              pmem_resp,
  output logic [DATA_W-1:0] pmem_rdata,
  output logic              proto_err
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_LINES);
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  pmem_state_t       state;
  pmem_state_t       state_next;
  logic [IDX_W-1:0]  line;
  logic              op_read;
  logic [8:0]        lat_cnt;
  logic [8:0]        lat_load;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] rd_beat;
  logic              accept;
  logic              wait_done;
  logic              last_beat;
  logic              mem_we;
  logic              rd_load;

  logic [DATA_W-1:0] mem [DEPTH_LINES][BURST_LEN];

  logic unused_addr;
  assign unused_addr = ^{pmem_addr[ADDR_W-1:OFFSET_BITS+IDX_W], pmem_addr[OFFSET_BITS-1:0]};

  assign wait_done = (state == WAIT) && (lat_cnt == '0);
  assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));

`ifdef PMEM_RESP_JITTER_EN
  logic [7:0] lfsr;

  pmem_lfsr #(.SEED(8'hA5)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .q   (lfsr)
  );

  assign lat_load = 9'(LATENCY - 1) + 9'(lfsr[2:0]);
`else
  assign lat_load = 9'(LATENCY - 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pmem_read || pmem_write) state_next = WAIT;
      WAIT:    if (lat_cnt == '0) state_next = op_read ? RBURST : WBURST;
      RBURST,
      WBURST:  if (last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data is prefetched one cycle ahead so it is registered yet aligned with resp.
  always_comb begin
    pmem_resp = (state == RBURST) || (state == WBURST);
    mem_we    = (state == WBURST);
    accept    = (state == IDLE) && (pmem_read || pmem_write);
    rd_load   = 1'b0;
    rd_beat   = '0;
    if (wait_done && op_read) begin
      rd_load = 1'b1;
    end else if ((state == RBURST) && !last_beat) begin
      rd_load = 1'b1;
      rd_beat = beat + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line       <= '0;
      op_read    <= 1'b0;
      lat_cnt    <= '0;
      beat       <= '0;
      pmem_rdata <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (accept) begin
        line    <= pmem_addr[OFFSET_BITS +: IDX_W];
        op_read <= pmem_read;
        lat_cnt <= lat_load;
        if (pmem_read && pmem_write) proto_err <= 1'b1;
      end else if ((state == WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 9'd1;
      end

      if (wait_done) begin
        beat <= '0;
      end else if (pmem_resp) begin
        beat <= last_beat ? '0 : beat + 1'b1;
      end

      if (rd_load) pmem_rdata <= mem[line][rd_beat];
    end
  end

  // Backing store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[line][beat] <= pmem_wdata;
  end

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed scoreboard bench for pmem_burst_responder (default build, LATENCY=10).
module tb_pmem_burst_responder;
  import pmem_pkg::*;

  localparam int LAT   = 10;
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_addr;
  logic [63:0] pmem_wdata;
  logic        pmem_resp;
  logic [63:0] pmem_rdata;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [256][4];
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  pmem_burst_responder #(
    .ADDR_W      (32),
    .DATA_W      (64),
    .BURST_LEN   (BURST),
    .LATENCY     (LAT),
    .DEPTH_LINES (256)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_resp  (pmem_resp),
    .pmem_rdata (pmem_rdata),
    .proto_err  (proto_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction starting at a negedge; nbeats < BURST pulses rst after that many beats.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input line_t wline, input int nbeats);
    int idx;
    int waited;
    logic [63:0] exp;
    idx    = int'(addr[12:5]);
    waited = 0;
    if (rd) begin
      for (int i = 0; i < BURST; i++) exp_q.push_back(model[idx][i]);
    end
    pmem_read  = rd;
    pmem_write = wr;
    pmem_addr  = addr;
    pmem_wdata = wline[0];
    do begin
      @(negedge clk);
      waited++;
    end while (!pmem_resp && waited < LAT + 20);
`ifndef PMEM_RESP_JITTER_EN
    check("first_resp_latency", 64'(waited), 64'(LAT + 1));
`endif
    if (!pmem_resp) begin
      check("first_resp_timeout", {63'd0, pmem_resp}, 64'd1);
      exp_q.delete();
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      return;
    end
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0) @(negedge clk);
      check("resp_beat", {63'd0, pmem_resp}, 64'd1);
      if (rd) begin
        exp = exp_q.pop_front();
        check("rdata_beat", pmem_rdata, exp);
      end else begin
        pmem_wdata     = wline[b];
        model[idx][b]  = wline[b];
      end
    end
    if (nbeats < BURST) begin
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check("resp_after_rst", {63'd0, pmem_resp}, 64'd0);
      check("proto_err_after_rst", {63'd0, proto_err}, 64'd0);
      @(negedge clk);
      rst        = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      @(negedge clk);
      return;
    end
    @(negedge clk);
    check("done_gap", {63'd0, pmem_resp}, 64'd0);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    @(negedge clk);
    check("idle_after_done", {63'd0, pmem_resp}, 64'd0);
  endtask

  initial begin
    line_t l_a;
    line_t l_old;
    line_t l_new;
    line_t l_zero;

    l_a    = '{64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    l_old  = '{64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    l_new  = '{64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
               64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    l_zero = '0;

    rst        = 1'b1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_resp", {63'd0, pmem_resp}, 64'd0);
      check("idle_rdata", pmem_rdata, 64'd0);
      check("idle_proto_err", {63'd0, proto_err}, 64'd0);
    end

    txn(1'b0, 1'b1, 32'h0000_0040, l_a, BURST);
    txn(1'b1, 1'b0, 32'h0000_0040, l_zero, BURST);
    txn(1'b1, 1'b0, 32'h0000_2040, l_zero, BURST);
    txn(1'b0, 1'b1, 32'h0000_00A0, l_old, BURST);

    txn(1'b1, 1'b1, 32'h0000_0040, l_new, BURST);
    check("proto_err_set", {63'd0, proto_err}, 64'd1);
    txn(1'b1, 1'b0, 32'h0000_00A0, l_zero, BURST);
    check("proto_err_sticky", {63'd0, proto_err}, 64'd1);

    txn(1'b0, 1'b1, 32'h0000_00A0, l_new, 2);
    txn(1'b1, 1'b0, 32'h0000_00A0, l_zero, BURST);
    check("model_partial_beat2", model[5][2], 64'hCCCC_CCCC_CCCC_CCCC);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
